// File: rtl/div_pkg.sv
// Shared constants for the divider and its BCD formatter.
// State encoding, blank digit code and default operand/digit widths.
package div_pkg;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned DIV_D = 3;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one binary bit.
module bcd_dabble_step
  import div_pkg::*;
#(
  parameter int unsigned D = DIV_D
) (
  input  logic [4*D-1:0] acc_i,
  input  logic           bit_i,
  output logic [4*D-1:0] acc_o
);

  logic [4*D-1:0] adj;

  // Digits are adjusted independently; carries never cross a digit boundary.
  always_comb begin
    adj = acc_i;
    for (int i = 0; i < int'(D); i++) begin
      if (acc_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
      end
    end
    acc_o = {adj[4*D-2:0], bit_i};
  end

endmodule

// File: rtl/div_bcd_formatter.sv
// Captures each finished quotient/remainder pair from the divider and converts both
// to packed BCD with a bit-serial double-dabble engine; divide errors become blanks.
module div_bcd_formatter
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W,
  parameter int unsigned D = DIV_D
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           div_done,
  input  logic           div_error,
  input  logic [W-1:0]   quotient,
  input  logic [W-1:0]   remainder,
  output logic [4*D-1:0] q_bcd,
  output logic [4*D-1:0] r_bcd,
  output logic           out_valid,
  output logic           out_error,
  output logic           busy,
  output logic           overrun
);

  localparam int unsigned CW = $clog2(W) + 1;

  state_t         state;
  logic [CW-1:0]  counter;
  logic           done_prev;
  logic [W-1:0]   q_bin;
  logic [W-1:0]   r_bin;
  logic [4*D-1:0] q_acc;
  logic [4*D-1:0] r_acc;
  logic [4*D-1:0] q_acc_next;
  logic [4*D-1:0] r_acc_next;
  logic           capture;

  // A level-held div_done only counts on its rising edge.
  assign capture = div_done & ~done_prev;

  bcd_dabble_step #(.D(D)) u_q_step (
    .acc_i (q_acc),
    .bit_i (q_bin[W-1]),
    .acc_o (q_acc_next)
  );

  bcd_dabble_step #(.D(D)) u_r_step (
    .acc_i (r_acc),
    .bit_i (r_bin[W-1]),
    .acc_o (r_acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      done_prev <= 1'b1;
      q_bin     <= '0;
      r_bin     <= '0;
      q_acc     <= '0;
      r_acc     <= '0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_prev <= div_done;
      out_valid <= 1'b0;

      // Requests arriving during SHIFT or FINISH are dropped, never queued.
      if (capture && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            if (div_error) begin
              q_bcd     <= {D{BCD_BLANK}};
              r_bcd     <= {D{BCD_BLANK}};
              out_error <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              q_bin   <= quotient;
              r_bin   <= remainder;
              q_acc   <= '0;
              r_acc   <= '0;
              counter <= '0;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          q_acc   <= q_acc_next;
          r_acc   <= r_acc_next;
          q_bin   <= {q_bin[W-2:0], 1'b0};
          r_bin   <= {r_bin[W-2:0], 1'b0};
          counter <= counter + 1'b1;
          if (counter == CW'(W - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          q_bcd     <= q_acc;
          r_bcd     <= r_acc;
          out_error <= 1'b0;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed cases with literal expected BCD values.
module tb_div_bcd_formatter;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned BW = 4 * D;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          div_done = 1'b0;
  logic          div_error = 1'b0;
  logic [W-1:0]  quotient = '0;
  logic [W-1:0]  remainder = '0;
  logic [BW-1:0] q_bcd;
  logic [BW-1:0] r_bcd;
  logic          out_valid;
  logic          out_error;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  div_bcd_formatter #(.W(W), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_done  (div_done),
    .div_error (div_error),
    .quotient  (quotient),
    .remainder (remainder),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .out_valid (out_valid),
    .out_error (out_error),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(D); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted capture at cycle c yields a result at cycle c+W+1;
  // any further request up to and including that cycle is an overrun.
  logic          m_prev = 1'b1;
  bit            m_pend = 1'b0;
  int            m_due = 0;
  int            cyc = 0;
  logic [W-1:0]  m_q = '0;
  logic [W-1:0]  m_r = '0;
  logic [BW-1:0] e_q = '0;
  logic [BW-1:0] e_r = '0;
  logic          e_valid = 1'b0;
  logic          e_err = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_ovr = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_prev  = 1'b1;
        m_pend  = 1'b0;
        e_q     = '0;
        e_r     = '0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_busy  = 1'b0;
        e_ovr   = 1'b0;
      end else begin
        bit req;
        bit fin;
        cyc++;
        req     = div_done && !m_prev;
        m_prev  = div_done;
        e_valid = 1'b0;
        fin     = 1'b0;
        if (m_pend && cyc == m_due) begin
          e_q     = to_bcd(int'(m_q));
          e_r     = to_bcd(int'(m_r));
          e_err   = 1'b0;
          e_valid = 1'b1;
          m_pend  = 1'b0;
          fin     = 1'b1;
        end
        if (req) begin
          if (m_pend || fin) begin
            e_ovr = 1'b1;
          end else if (div_error) begin
            e_q     = {D{4'hF}};
            e_r     = {D{4'hF}};
            e_err   = 1'b1;
            e_valid = 1'b1;
          end else begin
            m_pend = 1'b1;
            m_due  = cyc + int'(W) + 1;
            m_q    = quotient;
            m_r    = remainder;
          end
        end
        e_busy = m_pend;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_error", 32'(out_error), 32'(e_err));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("q_bcd", 32'(q_bcd), 32'(e_q));
      chk("r_bcd", 32'(r_bcd), 32'(e_r));
    end
  end

  // Single pulse capture; waits (bounded) for the result and checks literal values.
  task automatic directed(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic err, input logic [BW-1:0] exp_q,
                          input logic [BW-1:0] exp_r);
    bit found;
    int lat;
    bit saw_busy;
    found    = 1'b0;
    lat      = -1;
    saw_busy = 1'b0;
    @(negedge clk);
    quotient  = q;
    remainder = r;
    div_error = err;
    div_done  = 1'b1;
    for (int i = 0; i < int'(W) + 4 && !found; i++) begin
      @(negedge clk);
      if (i == 0) begin
        div_done  = 1'b0;
        div_error = 1'b0;
        quotient  = W'($urandom);
        remainder = W'($urandom);
      end
      if (busy) saw_busy = 1'b1;
      if (out_valid) begin
        found = 1'b1;
        lat   = i;
      end
    end
    chk({name, " valid seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({name, " latency"}, 32'(lat), err ? 32'd0 : 32'(W + 1));
      chk({name, " q_bcd"}, 32'(q_bcd), 32'(exp_q));
      chk({name, " r_bcd"}, 32'(r_bcd), 32'(exp_r));
      chk({name, " out_error"}, 32'(out_error), 32'(err));
      chk({name, " busy seen"}, 32'(saw_busy), err ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int nvalid;
    if ((10 ** D) <= (2 ** W - 1)) begin
      $display("FAIL param: 10^D=%0d does not exceed 2^W-1=%0d", 10 ** D, 2 ** W - 1);
      $fatal(1, "bad parameters");
    end

    repeat (3) @(negedge clk);
    chk("reset q_bcd", 32'(q_bcd), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    directed("q5r0", 8'd5, 8'd0, 1'b0, 12'h005, 12'h000);
    directed("q31r7", 8'd31, 8'd7, 1'b0, 12'h031, 12'h007);
    directed("q255r254", 8'd255, 8'd254, 1'b0, 12'h255, 12'h254);
    directed("err", 8'd9, 8'd9, 1'b1, 12'hFFF, 12'hFFF);
    directed("q100r99", 8'd100, 8'd99, 1'b0, 12'h100, 12'h099);

    // Level-held div_done triggers exactly once.
    @(negedge clk);
    quotient  = 8'd3;
    remainder = 8'd1;
    div_done  = 1'b1;
    nvalid    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    div_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("held one valid", 32'(nvalid), 32'd1);
    chk("held q_bcd", 32'(q_bcd), 32'h003);
    chk("held r_bcd", 32'(r_bcd), 32'h001);
    chk("overrun clear", 32'(overrun), 32'd0);

    // Second rising edge three cycles after the accepted one.
    quotient = 8'd3;
    remainder = 8'd0;
    div_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    div_done = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    chk("overrun set", 32'(overrun), 32'd1);
    nvalid = 0;
    for (int i = 0; i < int'(W) + 4 && nvalid == 0; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("overrun first result", 32'(nvalid), 32'd1);
    chk("overrun q_bcd", 32'(q_bcd), 32'h003);

    // Reset during SHIFT discards the conversion.
    quotient  = 8'd50;
    remainder = 8'd9;
    div_done  = 1'b1;
    @(negedge clk);
    div_done = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset mid q_bcd", 32'(q_bcd), 32'h0);
    chk("reset mid busy", 32'(busy), 32'd0);
    chk("reset mid overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("reset no valid", 32'(nvalid), 32'd0);
    directed("q20r2", 8'd20, 8'd2, 1'b0, 12'h020, 12'h002);

    // Random traffic against the model, including overlaps and errors.
    for (int t = 0; t < 300; t++) begin
      int gap;
      int hold;
      gap  = int'($urandom_range(0, W + 4));
      hold = int'($urandom_range(1, 12));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        quotient  = W'($urandom);
        remainder = W'($urandom);
      end
      @(negedge clk);
      quotient  = W'($urandom);
      remainder = W'($urandom);
      div_error = ($urandom_range(0, 5) == 0);
      div_done  = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        quotient  = W'($urandom);
        remainder = W'($urandom);
      end
      div_done  = 1'b0;
      div_error = 1'b0;
    end
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
